multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width.
REQ-002 SHALL have parameter ITER, default 32, meaning iteration cycles per multiply or divide (equals WIDTH).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port ctrl_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_operandA  input  WIDTH  signed multiplicand or dividend.
REQ-006 SHALL have port data_operandB  input  WIDTH  signed multiplier or divisor.
REQ-007 SHALL have port ctrl_MULT  input  1  one-cycle start pulse for a multiply.
REQ-008 SHALL have port ctrl_DIV  input  1  one-cycle start pulse for a divide.
REQ-009 SHALL have port data_result  output  WIDTH  product low word or quotient.
REQ-010 SHALL have port data_exception  output  1  overflow or divide-by-zero flag, qualified by data_resultRDY.
REQ-011 SHALL have port data_resultRDY  output  1  one-cycle completion strobe.
REQ-012 SHALL have port ctrl_busy  output  1  high while an operation is in flight; used as the execute-stage stall.

Function
REQ-013 SHALL use a state machine IDLE, MULT, DIV, DONE.
REQ-014 SHALL, in IDLE, latch both operands on the cycle ctrl_MULT or ctrl_DIV is high and enter MULT or DIV the next cycle.
REQ-015 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are high together.
REQ-016 SHALL ignore ctrl_MULT and ctrl_DIV when not in IDLE; operands are not re-latched.
REQ-017 SHALL multiply by radix-2 Booth, one step per cycle for ITER cycles, forming the full 2*WIDTH signed product.
REQ-018 SHALL output the low WIDTH product bits; exception=1 when the upper WIDTH+1 product bits are not all equal.
REQ-019 SHALL divide by restoring division on operand magnitudes, one step per cycle for ITER cycles, with the quotient negated when the operand signs differ (truncation toward zero); the remainder is discarded.
REQ-020 SHALL, on divisor 0, skip iteration and go directly to DONE with result 0 and exception=1.
REQ-021 SHALL, on dividend 0x80000000 with divisor -1, return result 0x80000000 and exception=1.
REQ-022 SHALL give latency as follows, with the start pulse in cycle 0: data_resultRDY high in cycle ITER+1 (33) for exactly one cycle; on divide-by-zero, in cycle 1.
REQ-023 SHALL hold ctrl_busy high from cycle 1 through the cycle before data_resultRDY, and low in the RDY cycle.
REQ-024 SHALL return from DONE to IDLE after one cycle; a new start pulse is accepted in the DONE cycle and treated as if in IDLE.
REQ-025 SHALL hold data_result and data_exception stable from RDY until the next RDY.

Reset
REQ-026 SHALL, while ctrl_reset_n is 0, force state IDLE, data_result 0, data_exception 0, data_resultRDY 0, ctrl_busy 0 and clear internal registers, independent of clock.
REQ-027 SHALL, on reset mid-operation, abort with no RDY strobe; the first start after release proceeds normally.

Structure
REQ-028 SHALL define the state enum, WIDTH and ITER constants in shared package multdiv_pkg.
REQ-029 SHALL place the (WIDTH+1)-bit add/subtract shared by the Booth and restoring steps in sub-module multdiv_addsub.
REQ-030 SHALL be 120-400 lines of RTL excluding the package.

Verification
REQ-031 SHALL cover: MULT with A=7, B=-6 -> cycle 33: result 0xFFFFFFD6, exception 0, RDY one cycle; busy high cycles 1-32.
REQ-032 SHALL cover: MULT with A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1.
REQ-033 SHALL cover: DIV with A=-7, B=2 -> cycle 33: result 0xFFFFFFFD, exception 0; then DIV 0x80000000 / -1 -> 0x80000000, exception 1.
REQ-034 SHALL cover: DIV with A=5, B=0 -> cycle 1: RDY, result 0, exception 1; ctrl_DIV pulsed again in cycle 1 is accepted.
REQ-035 SHALL cover: MULT start, ctrl_reset_n low in cycle 10 -> outputs 0 immediately, no RDY; a later MULT 3*4 gives 12 at start+33.
REQ-036 SHALL cover: ctrl_MULT and ctrl_DIV together with A=6, B=3 -> result 18; ctrl_DIV pulsed in cycle 5 is ignored.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package multdiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/multdiv_addsub.sv
// Single adder/subtractor shared by the Booth and restoring-division steps.
module multdiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y
);
  assign o_y = i_sub ? (i_a - i_b) : (i_a + i_b);
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring), one bit per cycle,
// with a one-cycle completion strobe and a busy stall output.
module multdiv_unit #(
  parameter int WIDTH = multdiv_pkg::WIDTH,
  parameter int ITER  = multdiv_pkg::ITER
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             ctrl_busy
);
  import multdiv_pkg::*;

  localparam int CW = $clog2(ITER + 1);

  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  state_t           r_state;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_q1;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic [WIDTH:0]   w_add_a;
  logic [WIDTH:0]   w_add_b;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_booth;
  logic [WIDTH:0]   w_mul_acc;
  logic [WIDTH-1:0] w_mul_q;
  logic [WIDTH:0]   w_mul_hi;
  logic             w_mul_ovf;
  logic             w_div_ok;
  logic [WIDTH:0]   w_div_acc;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_quot;
  logic             w_div_ovf;

  // Booth adds/subtracts the sign-extended multiplicand; division trial-subtracts the divisor.
  always_comb begin
    w_add_a = r_acc;
    w_add_b = {r_m[WIDTH-1], r_m};
    w_sub   = r_q[0] & ~r_q1;
    if (r_state == S_DIV) begin
      w_add_a = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
      w_add_b = {1'b0, r_m};
      w_sub   = 1'b1;
    end
  end

  multdiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (w_sub),
    .o_y   (w_sum)
  );

  assign w_booth   = (r_q[0] ^ r_q1) ? w_sum : r_acc;
  assign w_mul_acc = {w_booth[WIDTH], w_booth[WIDTH:1]};
  assign w_mul_q   = {w_booth[0], r_q[WIDTH-1:1]};
  assign w_mul_hi  = {w_mul_acc[WIDTH-1:0], w_mul_q[WIDTH-1]};
  assign w_mul_ovf = ~(&w_mul_hi) & (|w_mul_hi);

  assign w_div_ok  = ~w_sum[WIDTH];
  assign w_div_acc = w_div_ok ? w_sum : w_add_a;
  assign w_div_q   = {r_q[WIDTH-2:0], w_div_ok};
  assign w_quot    = r_neg ? (~w_div_q + 1'b1) : w_div_q;
  // Same-sign quotient with the top bit set can only be MIN / -1.
  assign w_div_ovf = ~r_neg & w_div_q[WIDTH-1];

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_q1     <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (ctrl_MULT) begin
            r_state <= S_MULT;
            r_busy  <= 1'b1;
            r_acc   <= '0;
            r_m     <= data_operandA;
            r_q     <= data_operandB;
            r_q1    <= 1'b0;
            r_cnt   <= CW'(ITER - 1);
          end else if (ctrl_DIV) begin
            if (data_operandB == '0) begin
              r_state  <= S_DONE;
              r_rdy    <= 1'b1;
              r_result <= '0;
              r_exc    <= 1'b1;
            end else begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
              r_acc   <= '0;
              r_m     <= f_mag(data_operandB);
              r_q     <= f_mag(data_operandA);
              r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              r_cnt   <= CW'(ITER - 1);
            end
          end
        end
        S_MULT: begin
          r_acc <= w_mul_acc;
          r_q   <= w_mul_q;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_rdy    <= 1'b1;
            r_result <= w_mul_q;
            r_exc    <= w_mul_ovf;
          end
        end
        S_DIV: begin
          r_acc <= w_div_acc;
          r_q   <= w_div_q;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_rdy    <= 1'b1;
            r_result <= w_quot;
            r_exc    <= w_div_ovf;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign ctrl_busy      = r_busy;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, busy window, results, exceptions, reset abort.
module tb_multdiv_unit;
  logic        clock;
  logic        ctrl_reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        ctrl_busy;

  int total = 0;
  int bad   = 0;

  multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .ctrl_busy      (ctrl_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse a start in the current cycle; returns in cycle 1 of the operation.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic run_check(input string tag, input int start_cyc, input logic [31:0] exp_res,
                           input logic exp_exc, input int exp_lat);
    int cyc;
    int busy_bad;
    cyc      = start_cyc;
    busy_bad = 0;
    while (data_resultRDY !== 1'b1 && cyc < 40) begin
      if (ctrl_busy !== 1'b1) busy_bad++;
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    chk({tag, "_result"}, 64'(data_result), 64'(exp_res));
    chk({tag, "_exception"}, 64'(data_exception), 64'(exp_exc));
    chk({tag, "_busy_at_rdy"}, 64'(ctrl_busy), 64'd0);
    @(negedge clock);
    chk({tag, "_rdy_one_cycle"}, 64'(data_resultRDY), 64'd0);
    chk({tag, "_result_held"}, 64'(data_result), 64'(exp_res));
  endtask

  initial begin
    int rdy_seen;
    ctrl_reset_n  = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #3;
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exception", 64'(data_exception), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    chk("reset_busy", 64'(ctrl_busy), 64'd0);
    @(negedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(negedge clock);

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    run_check("mul_7_m6", 1, 32'hFFFF_FFD6, 1'b0, 33);

    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    run_check("mul_ovf", 1, 32'h0000_0000, 1'b1, 33);

    start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("mul_min_m1", 1, 32'h8000_0000, 1'b1, 33);

    start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("mul_m1_m1", 1, 32'h0000_0001, 1'b0, 33);

    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_check("div_m7_2", 1, 32'hFFFF_FFFD, 1'b0, 33);

    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("div_min_m1", 1, 32'h8000_0000, 1'b1, 33);

    start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_check("div_7_m2", 1, 32'hFFFF_FFFD, 1'b0, 33);

    // Divide by zero completes in cycle 1; a new start in that DONE cycle is accepted.
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    chk("div0_rdy", 64'(data_resultRDY), 64'd1);
    chk("div0_result", 64'(data_result), 64'd0);
    chk("div0_exception", 64'(data_exception), 64'd1);
    chk("div0_busy", 64'(ctrl_busy), 64'd0);
    start_op(1'b0, 1'b1, 32'd20, 32'd3);
    run_check("div_20_3_from_done", 1, 32'd6, 1'b0, 33);

    // Both starts together: multiply wins; a divide pulse mid-operation is ignored.
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    repeat (4) @(negedge clock);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    run_check("mul_priority", 6, 32'd18, 1'b0, 33);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY === 1'b1 || ctrl_busy === 1'b1) rdy_seen++;
      @(negedge clock);
    end
    chk("ignored_div_no_activity", 64'(rdy_seen), 64'd0);

    // Reset in cycle 10 of a multiply aborts it immediately.
    start_op(1'b1, 1'b0, 32'd5, 32'd9);
    repeat (9) @(negedge clock);
    chk("pre_reset_busy", 64'(ctrl_busy), 64'd1);
    ctrl_reset_n = 1'b0;
    #1;
    chk("abort_result", 64'(data_result), 64'd0);
    chk("abort_exception", 64'(data_exception), 64'd0);
    chk("abort_rdy", 64'(data_resultRDY), 64'd0);
    chk("abort_busy", 64'(ctrl_busy), 64'd0);
    @(negedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY === 1'b1) rdy_seen++;
      @(negedge clock);
    end
    chk("abort_no_rdy", 64'(rdy_seen), 64'd0);
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    run_check("mul_3_4_after_reset", 1, 32'd12, 1'b0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
